// File: rtl/progmem_loader.sv
// progmem_loader: boot loader that turns a framed byte stream into program memory writes and holds the core until a frame verifies
// Ports: clk, rst (async, active-high); in_data/in_valid/in_ready byte stream input;
//   pm_we/pm_addr/pm_wdata program memory write port; core_hold halts the core;
//   done/error report the outcome of the last frame.
module progmem_loader #(
  parameter int PROG_WIDTH = 11,
  parameter int ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [PROG_WIDTH-1:0] pm_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [8:0] len_q, len_d, idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [2:0] op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PROG_WIDTH-1:0] wdata_q, wdata_d;
  logic rdy_q, we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d, xfer;
  assign xfer = in_valid && rdy_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    if (xfer) begin
      case (state_q)
        LEN: begin
          // a zero LEN byte becomes 256 via the ninth bit
          len_d   = {in_data == 8'd0, in_data};
          idx_d   = '0;
          sum_d   = in_data;
          state_d = HI;
        end
        HI: begin
          op_d    = in_data[2:0];
          sum_d   = sum_q + in_data;
          err_d   = |in_data[7:3];
          state_d = |in_data[7:3] ? ERR : LO;
        end
        LO: begin
          sum_d   = sum_q + in_data;
          we_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(idx_q);
          wdata_d = PROG_WIDTH'({op_q, in_data});
          idx_d   = idx_q + 9'd1;
          state_d = (idx_q + 9'd1 == len_q) ? CSUM : HI;
        end
        CSUM: begin
          done_d  = in_data == sum_q;
          err_d   = in_data != sum_q;
          hold_d  = in_data != sum_q;
          state_d = in_data == sum_q ? DONE : ERR;
        end
        default: if (in_data == SYNC_BYTE) begin
          state_d = LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= 1'b1;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign in_ready  = rdy_q;
  assign pm_we     = we_q;
  assign pm_addr   = addr_q;
  assign pm_wdata  = wdata_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign error     = err_q;
endmodule

// File: tb/tb_progmem_loader.sv
// tb_progmem_loader: randomized frame stimulus checked against a stream-parsing reference model
module tb_progmem_loader;
  logic clk = 0, rst = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, pm_we, core_hold, done, error;
  logic [7:0] pm_addr;
  logic [10:0] pm_wdata;
  int n_chk = 0, n_pass = 0;
  logic [7:0] stim[$];
  logic [18:0] exp_w[$], obs_w[$];
  logic m_done = 0, m_err = 0, m_hold = 1;
  bit gap = 0;
  always #5 clk = ~clk;
  progmem_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .core_hold(core_hold), .done(done), .error(error)
  );
  always @(negedge clk) if (pm_we) obs_w.push_back({pm_addr, pm_wdata});
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic void model_run();
    int i, n;
    logic [7:0] hi, lo, s;
    bit bad;
    i = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin i++; continue; end
      i++;
      m_hold = 1; m_done = 0; m_err = 0;
      if (i >= stim.size()) return;
      n = (stim[i] == 0) ? 256 : int'(stim[i]);
      s = stim[i];
      i++;
      bad = 0;
      for (int k = 0; k < n; k++) begin
        if (i >= stim.size()) return;
        hi = stim[i]; i++;
        if (hi[7:3] != 0) begin m_err = 1; bad = 1; break; end
        if (i >= stim.size()) return;
        lo = stim[i]; i++;
        s = s + hi + lo;
        exp_w.push_back({k[7:0], hi[2:0], lo});
      end
      if (bad) continue;
      if (i >= stim.size()) return;
      if (stim[i] == s) begin m_done = 1; m_hold = 0; end
      else m_err = 1;
      i++;
    end
  endfunction
  task automatic send(input logic [7:0] b);
    int t = 0;
    if (gap) repeat ($urandom_range(0, 3)) begin
      in_valid = 0;
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_data = b;
    in_valid = 1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic push_good(input logic [7:0] cs);
    stim.push_back(8'hA5); stim.push_back(8'h02);
    stim.push_back(8'h02); stim.push_back(8'h0A);
    stim.push_back(8'h03); stim.push_back(8'h00);
    stim.push_back(cs);
  endtask
  task automatic reset_chk(input string tag);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_we"}, pm_we, 0);
    chk({tag, "_addr"}, pm_addr, 0);
    chk({tag, "_wdata"}, pm_wdata, 0);
    chk({tag, "_hold"}, core_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, error, 0);
  endtask
  task automatic check_writes(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_nwr"}, obs_w.size(), exp_w.size());
    foreach (exp_w[k]) if (k < obs_w.size()) chk({tag, "_wr"}, obs_w[k], exp_w[k]);
    obs_w.delete();
    exp_w.delete();
    stim.delete();
  endtask
  task automatic run(input string tag, input int sync_idx);
    foreach (stim[k]) begin
      send(stim[k]);
      if (k == sync_idx) begin
        chk({tag, "_sync_hold"}, core_hold, 1);
        chk({tag, "_sync_done"}, done, 0);
        chk({tag, "_sync_err"}, error, 0);
      end
    end
    model_run();
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_err"}, error, m_err);
    chk({tag, "_hold"}, core_hold, m_hold);
    check_writes(tag);
  endtask
  initial begin
    int n;
    logic [7:0] s, h, l;
    #2 rst = 1;
    #1 reset_chk("por");
    @(negedge clk);
    rst = 0;
    chk("rdy_at_release", in_ready, 0);
    @(negedge clk);
    chk("rdy_after_edge", in_ready, 1);
    push_good(8'h11);
    run("good", 0);
    push_good(8'h12);
    run("badcs", 0);
    stim.push_back(8'h00); stim.push_back(8'hFF); stim.push_back(8'h3C);
    push_good(8'h11);
    run("junk", 3);
    stim.push_back(8'hA5); stim.push_back(8'h01); stim.push_back(8'h08);
    run("badhi", 0);
    gap = 1;
    push_good(8'h11);
    run("recover", 0);
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1)) stim.push_back(8'($urandom_range(0, 8'hA4)));
      n = $urandom_range(1, 24);
      s = 8'(n);
      stim.push_back(8'hA5);
      stim.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
        h = 8'($urandom_range(0, 7));
        l = (k % 5 == 0) ? 8'hA5 : 8'($urandom);
        stim.push_back(h);
        stim.push_back(l);
        s = s + h + l;
      end
      stim.push_back(r % 3 == 2 ? s + 8'd1 : s);
      run($sformatf("rand%0d", r), -1);
    end
    s = 8'h00;
    stim.push_back(8'hA5);
    stim.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      h = 8'($urandom_range(0, 7));
      l = 8'($urandom);
      stim.push_back(h);
      stim.push_back(l);
      s = s + h + l;
    end
    stim.push_back(s);
    run("full", 0);
    stim.push_back(8'hA5);
    stim.push_back(8'h00);
    for (int k = 0; k < 101; k++) begin
      stim.push_back(8'($urandom_range(0, 7)));
      stim.push_back(8'($urandom));
    end
    foreach (stim[k]) send(stim[k]);
    @(negedge clk);
    #2 rst = 1;
    #1 reset_chk("midrst");
    model_run();
    m_done = 0; m_err = 0; m_hold = 1;
    check_writes("midrst");
    rst = 0;
    @(negedge clk);
    chk("midrst_rdy_back", in_ready, 1);
    gap = 0;
    push_good(8'h11);
    run("post", 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
